alu_arbiter: RTL and testbench

Shares one instance of the single-cycle CPU's combinational `alu` between two requesters, such as the integer pipe and a multi-cycle helper. It grants requests round-robin and issues at most one ALU operation per cycle. Each result is registered into a one-entry response buffer owned by the requester that issued it. The block sits between the requesters and the `alu`, and is the only driver of the ALU's `a`, `b` and `alu_func` inputs.

---
 rtl/alu_pkg.sv | 24 ++
 rtl/alu.sv | 26 ++
 rtl/rr_arb2.sv | 37 +++
 rtl/alu_arbiter.sv | 100 ++++++++++
 tb/tb_alu_arbiter.sv | 173 +++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: function codes, widths, requester index and slot state types.
package alu_pkg;

  localparam int WIDTH  = 32;
  localparam int FUNC_W = 3;

  localparam logic [FUNC_W-1:0] ALU_ADD = 3'b001;
  localparam logic [FUNC_W-1:0] ALU_SUB = 3'b010;
  localparam logic [FUNC_W-1:0] ALU_AND = 3'b011;
  localparam logic [FUNC_W-1:0] ALU_OR  = 3'b100;
  localparam logic [FUNC_W-1:0] ALU_SLT = 3'b101;

  typedef logic req_idx_t;

  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_t;

  function automatic logic [1:0] idx_onehot(input req_idx_t idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/alu.sv
// Combinational single-cycle ALU; zero latency, no flow control.
// Codes outside the defined set produce zero.
module alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0]  a,
  input  logic [WIDTH-1:0]  b,
  input  logic [FUNC_W-1:0] alu_func,
  output logic [WIDTH-1:0]  data_out
);

  always_comb begin
    data_out = '0;
    case (alu_func)
      ALU_ADD: data_out = a + b;
      ALU_SUB: data_out = a - b;
      ALU_AND: data_out = a & b;
      ALU_OR:  data_out = a | b;
      ALU_SLT: data_out = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      default: data_out = '0;
    endcase
  end

endmodule

// File: rtl/rr_arb2.sv
// Two-way round-robin grant, combinational grant with registered last_grant.
// o_sel follows the granted requester, or stays on the last one when idle.
module rr_arb2
  import alu_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] i_elig,
  output logic [1:0] o_grant,
  output req_idx_t   o_sel
);

  req_idx_t r_last_grant;

  always_comb begin
    o_grant = 2'b00;
    case (i_elig)
      2'b01:   o_grant = 2'b01;
      2'b10:   o_grant = 2'b10;
      2'b11:   o_grant = idx_onehot(~r_last_grant);
      default: o_grant = 2'b00;
    endcase
  end

  always_comb begin
    o_sel = r_last_grant;
    if (o_grant[1])      o_sel = 1'b1;
    else if (o_grant[0]) o_sel = 1'b0;
  end

  // Reset to 1 so requester 0 wins the first contention.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)           r_last_grant <= 1'b1;
    else if (|o_grant) r_last_grant <= o_grant[1];
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one ALU between two requesters round-robin; results land in a per-requester slot 1 cycle later.
// A requester is only readied when its slot is empty or being drained this cycle.
module alu_arbiter #(
  parameter int WIDTH  = 32,
  parameter int FUNC_W = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        req_valid,
  output logic [1:0]        req_ready,
  input  logic [WIDTH-1:0]  req_a0,
  input  logic [WIDTH-1:0]  req_b0,
  input  logic [FUNC_W-1:0] req_func0,
  input  logic [WIDTH-1:0]  req_a1,
  input  logic [WIDTH-1:0]  req_b1,
  input  logic [FUNC_W-1:0] req_func1,
  output logic [1:0]        rsp_valid,
  input  logic [1:0]        rsp_ready,
  output logic [WIDTH-1:0]  rsp_data0,
  output logic [WIDTH-1:0]  rsp_data1
);

  import alu_pkg::*;

  logic [WIDTH-1:0]  w_req_a    [2];
  logic [WIDTH-1:0]  w_req_b    [2];
  logic [FUNC_W-1:0] w_req_func [2];
  logic [1:0]        w_free;
  logic [1:0]        w_elig;
  logic [1:0]        w_grant;
  req_idx_t          w_sel;
  logic [WIDTH-1:0]  w_alu_a;
  logic [WIDTH-1:0]  w_alu_b;
  logic [FUNC_W-1:0] w_alu_func;
  logic [WIDTH-1:0]  w_alu_out;

  assign w_req_a[0]    = req_a0;
  assign w_req_b[0]    = req_b0;
  assign w_req_func[0] = req_func0;
  assign w_req_a[1]    = req_a1;
  assign w_req_b[1]    = req_b1;
  assign w_req_func[1] = req_func1;

  // Gating with rst keeps req_ready low for the whole reset window.
  assign w_elig    = req_valid & w_free & {2{~rst}};
  assign req_ready = w_grant;

  rr_arb2 u_rr_arb2 (
    .clk     (clk),
    .rst     (rst),
    .i_elig  (w_elig),
    .o_grant (w_grant),
    .o_sel   (w_sel)
  );

  assign w_alu_a    = w_req_a[w_sel];
  assign w_alu_b    = w_req_b[w_sel];
  assign w_alu_func = w_req_func[w_sel];

  alu #(
    .WIDTH (WIDTH)
  ) u_alu (
    .a        (w_alu_a),
    .b        (w_alu_b),
    .alu_func (w_alu_func),
    .data_out (w_alu_out)
  );

  for (genvar gi = 0; gi < 2; gi++) begin : g_slot
    slot_state_t      r_state;
    slot_state_t      w_state_nxt;
    logic [WIDTH-1:0] r_data;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= SLOT_EMPTY;
      else     r_state <= w_state_nxt;
    end

    // A grant wins over a drain so a same-cycle refill keeps the slot full.
    always_comb begin
      w_state_nxt = r_state;
      if (w_grant[gi])
        w_state_nxt = SLOT_FULL;
      else if (r_state == SLOT_FULL && rsp_ready[gi])
        w_state_nxt = SLOT_EMPTY;
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst)              r_data <= '0;
      else if (w_grant[gi]) r_data <= w_alu_out;
    end

    assign w_free[gi]    = (r_state == SLOT_EMPTY) || rsp_ready[gi];
    assign rsp_valid[gi] = (r_state == SLOT_FULL);
  end

  assign rsp_data0 = g_slot[0].r_data;
  assign rsp_data1 = g_slot[1].r_data;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed table-driven bench for alu_arbiter plus hand-written back-pressure and reset sequences.
module tb_alu_arbiter;
  import alu_pkg::*;

  localparam int W = 32;

  logic          clk;
  logic          rst;
  logic [1:0]    req_valid;
  logic [1:0]    req_ready;
  logic [W-1:0]  req_a0, req_b0, req_a1, req_b1;
  logic [2:0]    req_func0, req_func1;
  logic [1:0]    rsp_valid;
  logic [1:0]    rsp_ready;
  logic [W-1:0]  rsp_data0, rsp_data1;

  int n_checks = 0;
  int n_fail   = 0;

  alu_arbiter #(.WIDTH(W), .FUNC_W(3)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a0    (req_a0),
    .req_b0    (req_b0),
    .req_func0 (req_func0),
    .req_a1    (req_a1),
    .req_b1    (req_b1),
    .req_func1 (req_func1),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data0 (rsp_data0),
    .rsp_data1 (rsp_data1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [1:0]   vld;
    logic [W-1:0] a0, b0;
    logic [2:0]   f0;
    logic [W-1:0] a1, b1;
    logic [2:0]   f1;
    logic [1:0]   rr;
    logic [1:0]   e_rdy;
    logic [1:0]   e_vld;
    logic [W-1:0] e_d0;
    logic [W-1:0] e_d1;
  } vec_t;

  vec_t tbl [10];

  function automatic vec_t mk(
    input logic [1:0] vld,
    input logic [W-1:0] a0, input logic [W-1:0] b0, input logic [2:0] f0,
    input logic [W-1:0] a1, input logic [W-1:0] b1, input logic [2:0] f1,
    input logic [1:0] rr, input logic [1:0] e_rdy, input logic [1:0] e_vld,
    input logic [W-1:0] e_d0, input logic [W-1:0] e_d1);
    vec_t v;
    v.vld = vld; v.a0 = a0; v.b0 = b0; v.f0 = f0;
    v.a1 = a1; v.b1 = b1; v.f1 = f1; v.rr = rr;
    v.e_rdy = e_rdy; v.e_vld = e_vld; v.e_d0 = e_d0; v.e_d1 = e_d1;
    return v;
  endfunction

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input vec_t v);
    req_valid = v.vld;
    req_a0 = v.a0; req_b0 = v.b0; req_func0 = v.f0;
    req_a1 = v.a1; req_b1 = v.b1; req_func1 = v.f1;
    rsp_ready = v.rr;
  endtask

  localparam logic [W-1:0] NEG25 = 32'hFFFF_FFE7;

  initial begin
    tbl[0] = mk(2'b11, 25, 24, ALU_SUB, NEG25, 24, ALU_SLT, 2'b11, 2'b01, 2'b01, 1,  0);
    tbl[1] = mk(2'b11, 25, 24, ALU_SUB, NEG25, 24, ALU_SLT, 2'b11, 2'b10, 2'b10, 1,  1);
    tbl[2] = mk(2'b11, 25, 24, ALU_SUB, NEG25, 24, ALU_SLT, 2'b11, 2'b01, 2'b01, 1,  1);
    tbl[3] = mk(2'b11, 25, 24, ALU_SUB, NEG25, 24, ALU_SLT, 2'b11, 2'b10, 2'b10, 1,  1);
    tbl[4] = mk(2'b01, 25, 24, ALU_ADD, NEG25, 24, ALU_SLT, 2'b11, 2'b01, 2'b01, 49, 1);
    tbl[5] = mk(2'b01, 12, 10, ALU_AND, 0,     0,  ALU_ADD, 2'b01, 2'b01, 2'b01, 8,  1);
    tbl[6] = mk(2'b00, 0,  0,  ALU_ADD, 0,     0,  ALU_ADD, 2'b01, 2'b00, 2'b00, 8,  1);
    tbl[7] = mk(2'b10, 0,  0,  ALU_ADD, 12,    10, ALU_OR,  2'b00, 2'b10, 2'b10, 8,  14);
    tbl[8] = mk(2'b10, 0,  0,  ALU_ADD, 5,     7,  ALU_SUB, 2'b00, 2'b00, 2'b10, 8,  14);
    tbl[9] = mk(2'b11, 25, 24, ALU_ADD, 5,     7,  ALU_SUB, 2'b00, 2'b01, 2'b11, 49, 14);

    rst = 1'b1;
    req_valid = 2'b11; rsp_ready = 2'b00;
    req_a0 = 0; req_b0 = 0; req_func0 = ALU_ADD;
    req_a1 = 0; req_b1 = 0; req_func1 = ALU_ADD;

    #2;
    check("reset_req_ready", {30'd0, req_ready}, 0);
    check("reset_rsp_valid", {30'd0, rsp_valid}, 0);
    check("reset_rsp_data0", rsp_data0, 0);
    check("reset_rsp_data1", rsp_data1, 0);
    @(negedge clk);
    req_valid = 2'b00;
    rst = 1'b0;

    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      drive(tbl[i]);
      #1;
      check($sformatf("vec%0d_req_ready", i), {30'd0, req_ready}, {30'd0, tbl[i].e_rdy});
      @(posedge clk);
      #1;
      check($sformatf("vec%0d_rsp_valid", i), {30'd0, rsp_valid}, {30'd0, tbl[i].e_vld});
      check($sformatf("vec%0d_rsp_data0", i), rsp_data0, tbl[i].e_d0);
      check($sformatf("vec%0d_rsp_data1", i), rsp_data1, tbl[i].e_d1);
    end

    // Slot 1 stays full and undrained; requester 0 should win every cycle.
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      req_valid = 2'b11; rsp_ready = 2'b01;
      req_a0 = k; req_b0 = 100; req_func0 = ALU_ADD;
      req_a1 = 5; req_b1 = 7;   req_func1 = ALU_SUB;
      #1;
      check($sformatf("bp%0d_req_ready", k), {30'd0, req_ready}, 2'b01);
      @(posedge clk);
      #1;
      check($sformatf("bp%0d_rsp_valid", k), {30'd0, rsp_valid}, 2'b11);
      check($sformatf("bp%0d_rsp_data0", k), rsp_data0, 100 + k);
      check($sformatf("bp%0d_rsp_data1", k), rsp_data1, 14);
    end

    // Asynchronous reset between clock edges with both slots full.
    @(negedge clk);
    rsp_ready = 2'b00;
    #2;
    rst = 1'b1;
    #1;
    check("midrst_rsp_valid", {30'd0, rsp_valid}, 0);
    check("midrst_rsp_data0", rsp_data0, 0);
    check("midrst_rsp_data1", rsp_data1, 0);
    check("midrst_req_ready", {30'd0, req_ready}, 0);

    @(negedge clk);
    rst = 1'b0;
    req_valid = 2'b11; rsp_ready = 2'b11;
    req_a0 = 25; req_b0 = 24;    req_func0 = ALU_SUB;
    req_a1 = NEG25; req_b1 = 24; req_func1 = ALU_SLT;
    #1;
    check("postrst_grant0", {30'd0, req_ready}, 2'b01);
    @(posedge clk);
    #1;
    check("postrst_rsp_valid", {30'd0, rsp_valid}, 2'b01);
    check("postrst_rsp_data0", rsp_data0, 1);
    @(negedge clk);
    #1;
    check("postrst_grant1", {30'd0, req_ready}, 2'b10);
    @(posedge clk);
    #1;
    check("postrst_rsp_data1", rsp_data1, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
